fifo_wr_gen: RTL and testbench
==============================

# fifo_wr_gen

Write-side traffic generator for the FIFO loopback test. Lives in the write clock domain and is the producer feeding the dual-clock FIFO. It writes bursts of an incrementing 16-bit count, throttles on prog_full, and stalls during FIFO reset. The read-side checker downstream consumes that pattern and compares it against its own counter.

## Interface
- DATA_W, 16, width of written words
- BURST_LEN, 1536, words written per burst (≥1)
- START_VAL, 0, first data value after reset
- AUTO_RESTART, 1, 1 = start next burst when read side reports almost_empty; 0 = wait for start
- wr_clk  in  1  write-domain clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE/DONE
- wr_rst_busy  in  1  FIFO write-side reset busy
- full  in  1  FIFO full (write domain)
- prog_full  in  1  FIFO programmable-full (write domain); throttle input
- almost_empty  in  1  FIFO almost-empty, read-domain signal; asynchronous here
- fifo_wr_en  out  1  FIFO write enable, registered
- fifo_wr_data  out  DATA_W  FIFO write data, registered
- busy  out  1  high in WRITE/PAUSE
- done  out  1  one-cycle pulse after last word of a burst
- ovf_flag  out  1  sticky: a write was issued while full was high

## Operation
- States: IDLE, WRITE, PAUSE, DONE.
- IDLE → WRITE on start=1 and wr_rst_busy=0. start while wr_rst_busy=1 is ignored.
- WRITE → PAUSE when prog_full=1 or wr_rst_busy=1. PAUSE → WRITE when both are 0.
- WRITE → DONE when the BURST_LEN-th write is issued.
- DONE: the cycle entering DONE pulses done.
- DONE → WRITE on start=1, or when AUTO_RESTART=1 and almost_empty_s=1, in both cases only if wr_rst_busy=0.
- fifo_wr_en=1 exactly in the cycles where the registered state is WRITE and a word is being issued.
- Every cycle with fifo_wr_en=1 counts as a write. On that edge, fifo_wr_data increments and word_cnt increments.
- fifo_wr_data is not reset between bursts. It wraps from 2^DATA_W−1 to 0.
- word_cnt is width $clog2(BURST_LEN+1). It clears on entry to WRITE from IDLE or DONE.
- ovf_flag is set when fifo_wr_en=1 and full=1 in the same cycle. It clears only on rst. The write still counts, so the data gap is visible to the checker.
- almost_empty passes through a 2-flop synchronizer to give almost_empty_s.
- Reset values: state IDLE, fifo_wr_en 0, fifo_wr_data START_VAL, busy 0, done 0, ovf_flag 0, word_cnt 0, sync flops 0.
- rst mid-burst: all of the above on the next edge; the partial burst is abandoned.

## Timing
- Start latency: start sampled at edge k → fifo_wr_en=1 and fifo_wr_data=START_VAL valid after edge k.
- In steady state one word is written per cycle. A burst of BURST_LEN words with no throttle takes exactly BURST_LEN consecutive cycles.
- Throttle lag: prog_full or wr_rst_busy sampled high at edge k → fifo_wr_en=0 after edge k. The word issued after edge k−1 has already been written. prog_full thresholds must leave ≥2 free entries.
- Resume: prog_full sampled low at edge k → fifo_wr_en=1 after edge k, data continuing without a gap.
- done is high for the cycle after the edge on which the last write completes. fifo_wr_en is 0 in that same cycle.
- Auto-restart: the almost_empty rise adds 2 sync cycles plus 1 cycle before fifo_wr_en=1.
- start and prog_full in the same cycle while in IDLE: go to PAUSE, no write.

## Structure
- Shared package fifo_test_pkg holds:
  - DATA_W and BURST_LEN defaults, also used by the read-side checker for its expected count;
  - the state enum: IDLE, WRITE, PAUSE, DONE.
- One sub-module: sync_2ff, a 1-bit two-flop synchronizer for almost_empty.
- The FSM, data counter and word counter all sit in the top module.

## Test plan
- Reset then start, prog_full=0 → 1536 writes on consecutive cycles with data 0x0000..0x05FF; one-cycle done pulse; busy low afterwards.
- prog_full raised after word 100 for 20 cycles → fifo_wr_en low 20 cycles, then data resumes at 0x0064 with no skip or repeat; total still 1536.
- wr_rst_busy=1 during start → no write; after it drops and start is re-pulsed, the first data is 0x0000.
- AUTO_RESTART=1, almost_empty pulsed after done → second burst starts at 0x0600 within 3 cycles; run until wrap and check 0xFFFF → 0x0000.
- Force full=1 with fifo_wr_en=1 → ovf_flag sets and stays set through later bursts until rst.
- rst asserted at word 700 → next cycle fifo_wr_en=0, state IDLE, fifo_wr_data=START_VAL; a new start gives a full 1536-word burst.

Source files
------------

// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO loopback test: default geometry and the
// write-side generator state encoding. The read-side checker reuses the defaults.
package fifo_test_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_BURST_LEN = 1536;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StPause,
    StDone
  } wr_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a cycle to resolve.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_wr_gen.sv
// Write-side traffic generator: writes bursts of an incrementing count into
// the dual-clock FIFO, throttling on prog_full and stalling while the FIFO
// write side is in reset.
module fifo_wr_gen
  import fifo_test_pkg::*;
#(
  parameter int unsigned       DATA_W       = DEF_DATA_W,
  parameter int unsigned       BURST_LEN    = DEF_BURST_LEN,
  parameter logic [DATA_W-1:0] START_VAL    = '0,
  parameter bit                AUTO_RESTART = 1'b1
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_rst_busy,
  input  logic              full,
  input  logic              prog_full,
  input  logic              almost_empty,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf_flag
);

  localparam int unsigned     CntW    = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BURST_LEN - 1);

  wr_state_e         state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic almost_empty_s;
  logic last_word;
  logic launch;

  sync_2ff u_ae_sync (
    .clk_i (wr_clk),
    .rst_i (rst),
    .d_i   (almost_empty),
    .q_o   (almost_empty_s)
  );

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    data_d     = data_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    // The word on the bus is consumed by the FIFO at this edge.
    if (wr_en_q) begin
      data_d     = data_q + 1'b1;
      word_cnt_d = word_cnt_q + 1'b1;
      if (full) begin
        ovf_d = 1'b1;
      end
    end

    last_word = wr_en_q && (word_cnt_q == LastCnt);
    launch    = !wr_rst_busy &&
                (start || ((state_q == StDone) && AUTO_RESTART && almost_empty_s));

    unique case (state_q)
      StIdle, StDone: begin
        if (launch) begin
          word_cnt_d = '0;
          // A start that coincides with prog_full parks in PAUSE without writing.
          if (prog_full) begin
            state_d = StPause;
          end else begin
            state_d = StWrite;
            wr_en_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (last_word) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (prog_full || wr_rst_busy) begin
          state_d = StPause;
        end else begin
          wr_en_d = 1'b1;
        end
      end
      StPause: begin
        if (!prog_full && !wr_rst_busy) begin
          state_d = StWrite;
          wr_en_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StWrite) || (state_d == StPause);
  end

  // State and output registers; rst abandons any partial burst.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_en_q    <= 1'b0;
      data_q     <= START_VAL;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ovf_flag     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Bench for fifo_wr_gen: scoreboard of expected write words plus directed
// timing checks around start, throttle, auto-restart, overflow and reset.
module tb_fifo_wr_gen;
  import fifo_test_pkg::*;

  localparam int unsigned DW        = DEF_DATA_W;
  localparam int unsigned BL        = DEF_BURST_LEN;
  localparam logic [15:0] WrapStart = 16'hFF00;

  logic          wr_clk;
  logic          rst;
  logic          start;
  logic          start2;
  logic          wr_rst_busy;
  logic          full;
  logic          prog_full;
  logic          almost_empty;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          busy;
  logic          done;
  logic          ovf_flag;
  logic          w2_en;
  logic [DW-1:0] w2_data;
  logic          w2_busy;
  logic          w2_done;
  logic          w2_ovf;

  fifo_wr_gen #(
    .DATA_W       (DW),
    .BURST_LEN    (BL),
    .START_VAL    (16'h0000),
    .AUTO_RESTART (1'b1)
  ) u_dut (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .start        (start),
    .wr_rst_busy  (wr_rst_busy),
    .full         (full),
    .prog_full    (prog_full),
    .almost_empty (almost_empty),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .done         (done),
    .ovf_flag     (ovf_flag)
  );

  // Second instance starts near the top of the count range to reach the wrap quickly.
  fifo_wr_gen #(
    .DATA_W       (DW),
    .BURST_LEN    (BL),
    .START_VAL    (WrapStart),
    .AUTO_RESTART (1'b0)
  ) u_wrap (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .start        (start2),
    .wr_rst_busy  (1'b0),
    .full         (1'b0),
    .prog_full    (1'b0),
    .almost_empty (almost_empty),
    .fifo_wr_en   (w2_en),
    .fifo_wr_data (w2_data),
    .busy         (w2_busy),
    .done         (w2_done),
    .ovf_flag     (w2_ovf)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int          n_checks;
  int          n_pass;
  int          cyc;
  int          next_val;
  int          w2_writes;
  logic [15:0] exp_q[$];

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  // Reference model: a burst is BURST_LEN consecutive values of a 16-bit count.
  task automatic push_burst();
    for (int i = 0; i < int'(BL); i++) begin
      exp_q.push_back(16'(next_val));
      next_val = (next_val + 1) % 65536;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_val = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge wr_clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge wr_clk);
    start = 1'b0;
  endtask

  // Counts writes from the current negedge up to the done pulse.
  task automatic wait_burst_end(output int writes, output int cycles);
    bit seen;
    seen   = 1'b0;
    writes = 0;
    cycles = 0;
    for (int i = 0; i < 4 * int'(BL); i++) begin
      if (fifo_wr_en) writes++;
      if (done) begin
        seen   = 1'b1;
        cycles = i;
        break;
      end
      @(negedge wr_clk);
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      check("done_busy_low", {31'b0, busy}, 32'd0);
      @(negedge wr_clk);
      check("done_one_cycle", {31'b0, done}, 32'd0);
    end
  endtask

  // Monitor: every issued word must be the next one the model predicts.
  always @(negedge wr_clk) begin
    logic [15:0] exp_d;
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        check("write_with_empty_scoreboard", {31'b0, fifo_wr_en}, 32'd0);
      end else begin
        exp_d = exp_q.pop_front();
        check("wr_data", {16'b0, fifo_wr_data}, {16'b0, exp_d});
      end
    end
    if (done) check("done_with_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    if (w2_en) w2_writes++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w, c, t_last, mism, n2;
    bit wrapped;
    logic [15:0] e2, prev;

    n_checks = 0; n_pass = 0; cyc = 0; w2_writes = 0;
    start = 1'b0; start2 = 1'b0; wr_rst_busy = 1'b0; full = 1'b0;
    prog_full = 1'b0; almost_empty = 1'b0; rst = 1'b1;
    model_reset();
    @(negedge wr_clk);
    do_reset();

    // Reset values.
    check("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("rst_data", {16'b0, fifo_wr_data}, 32'h0000);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_ovf", {31'b0, ovf_flag}, 32'd0);

    // Unthrottled burst: BL consecutive cycles.
    push_burst();
    pulse_start();
    check("start_wr_en", {31'b0, fifo_wr_en}, 32'd1);
    check("start_data", {16'b0, fifo_wr_data}, 32'h0000);
    check("start_busy", {31'b0, busy}, 32'd1);
    wait_burst_end(w, c);
    check("t1_writes", w, BL);
    check("t1_cycles", c, BL);
    check("t1_sb_empty", exp_q.size(), 0);

    // prog_full held for 20 edges after word 100.
    do_reset();
    push_burst();
    pulse_start();
    w = 1;
    for (int i = 0; i < int'(BL) && w < 100; i++) begin
      @(negedge wr_clk);
      if (fifo_wr_en) w++;
    end
    check("t2_word100", {16'b0, fifo_wr_data}, 32'h0063);
    t_last    = cyc;
    prog_full = 1'b1;
    @(negedge wr_clk);
    check("t2_pause_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("t2_pause_busy", {31'b0, busy}, 32'd1);
    repeat (19) @(negedge wr_clk);
    prog_full = 1'b0;
    for (int i = 0; i < 10 && !fifo_wr_en; i++) @(negedge wr_clk);
    check("t2_gap", cyc - t_last - 1, 20);
    check("t2_resume_data", {16'b0, fifo_wr_data}, 32'h0064);
    wait_burst_end(w, c);
    check("t2_total", 100 + w, BL);
    check("t2_sb_empty", exp_q.size(), 0);

    // start ignored under wr_rst_busy; start with prog_full parks in PAUSE.
    do_reset();
    wr_rst_busy = 1'b1;
    pulse_start();
    repeat (2) @(negedge wr_clk);
    check("t3_rstbusy_no_wr", {31'b0, fifo_wr_en}, 32'd0);
    check("t3_rstbusy_idle", {31'b0, busy}, 32'd0);
    wr_rst_busy = 1'b0;
    prog_full   = 1'b1;
    push_burst();
    pulse_start();
    check("t3_pf_start_no_wr", {31'b0, fifo_wr_en}, 32'd0);
    check("t3_pf_start_busy", {31'b0, busy}, 32'd1);
    prog_full = 1'b0;
    @(negedge wr_clk);
    check("t3_first_wr_en", {31'b0, fifo_wr_en}, 32'd1);
    check("t3_first_data", {16'b0, fifo_wr_data}, 32'h0000);
    wait_burst_end(w, c);
    check("t3_writes", w, BL);
    check("t3_sb_empty", exp_q.size(), 0);

    // Count wrap on the second instance.
    start2 = 1'b1;
    @(negedge wr_clk);
    start2  = 1'b0;
    e2      = WrapStart;
    prev    = '0;
    mism    = 0;
    n2      = 0;
    wrapped = 1'b0;
    for (int i = 0; i < 4 * int'(BL); i++) begin
      if (w2_en) begin
        if (w2_data !== e2) mism++;
        if (n2 > 0 && prev == 16'hFFFF && w2_data == 16'h0000) wrapped = 1'b1;
        prev = w2_data;
        e2   = e2 + 16'd1;
        n2++;
      end
      if (w2_done) break;
      @(negedge wr_clk);
    end
    check("wrap_data_seq", mism, 0);
    check("wrap_seen", {31'b0, wrapped}, 32'd1);
    check("wrap_writes", n2, BL);

    // Auto-restart from DONE via synchronized almost_empty.
    push_burst();
    almost_empty = 1'b1;
    c = cyc;
    @(negedge wr_clk);
    almost_empty = 1'b0;
    for (int i = 0; i < 8 && !fifo_wr_en; i++) @(negedge wr_clk);
    check("t4_auto_latency", cyc - c, 3);
    check("t4_auto_data", {16'b0, fifo_wr_data}, 32'h0600);

    // Write into a full FIFO mid-burst.
    check("t5_ovf_clear", {31'b0, ovf_flag}, 32'd0);
    repeat (50) @(negedge wr_clk);
    check("t5_wr_active", {31'b0, fifo_wr_en}, 32'd1);
    full = 1'b1;
    @(negedge wr_clk);
    full = 1'b0;
    check("t5_ovf_set", {31'b0, ovf_flag}, 32'd1);
    wait_burst_end(w, c);
    check("t5_sb_empty", exp_q.size(), 0);
    check("t5_ovf_hold", {31'b0, ovf_flag}, 32'd1);
    check("t4_no_restart_wrap", w2_writes, BL);

    // Reset at word 700 of the next burst, then a fresh full burst.
    push_burst();
    pulse_start();
    check("t5_ovf_sticky", {31'b0, ovf_flag}, 32'd1);
    w = 1;
    for (int i = 0; i < int'(BL) && w < 700; i++) begin
      @(negedge wr_clk);
      if (fifo_wr_en) w++;
    end
    rst = 1'b1;
    @(negedge wr_clk);
    check("t6_rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    check("t6_rst_data", {16'b0, fifo_wr_data}, 32'h0000);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_ovf", {31'b0, ovf_flag}, 32'd0);
    check("t6_rst_state", {30'b0, u_dut.state_q}, {30'b0, StIdle});
    rst = 1'b0;
    model_reset();
    @(negedge wr_clk);
    push_burst();
    pulse_start();
    check("t6_restart_data", {16'b0, fifo_wr_data}, 32'h0000);
    wait_burst_end(w, c);
    check("t6_writes", w, BL);
    check("t6_sb_empty", exp_q.size(), 0);
    check("wrap_ovf_clear", {31'b0, w2_ovf}, 32'd0);
    check("wrap_idle", {31'b0, w2_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
